// File: rtl/fp_fma_sched_pkg.sv
// Shared types for the FMA scheduler: FMA request/response bundles, rounding-input
// bundle, the per-issue tag carried alongside the FMA pipeline, and reset constants.
package fp_fma_sched_pkg;

    typedef struct packed {
        logic fmadd;
        logic fmsub;
        logic fnmsub;
        logic fnmadd;
        logic fadd;
        logic fsub;
        logic fmul;
    } fp_operation_type;

    typedef struct packed {
        logic [31:0]      data1;
        logic [31:0]      data2;
        logic [31:0]      data3;
        logic [9:0]       class1;
        logic [9:0]       class2;
        logic [9:0]       class3;
        logic [1:0]       fmt;
        logic [2:0]       rm;
        fp_operation_type op;
    } fp_fma_in_type;

    typedef struct packed {
        logic        sig;
        logic [13:0] expo;
        logic [24:0] mant;
        logic [1:0]  rema;
        logic [1:0]  fmt;
        logic [2:0]  rm;
        logic [2:0]  grs;
        logic        snan;
        logic        qnan;
        logic        dbz;
        logic        infs;
        logic        zero;
        logic        diff;
    } fp_rnd_in_type;

    typedef struct packed {
        fp_rnd_in_type fp_rnd;
        logic          ready;
    } fp_fma_out_type;

    // id is wide enough for the largest supported requester count (4).
    typedef struct packed {
        logic       valid;
        logic       drop;
        logic [1:0] id;
    } fp_fma_sched_tag_type;

    localparam fp_fma_sched_tag_type init_fp_fma_sched_tag = '0;
    localparam fp_fma_in_type        init_fp_fma_in        = '0;
    localparam fp_rnd_in_type        init_fp_rnd_in        = '0;

endpackage

// File: rtl/fp_fma_sched_fifo.sv
// Per-requester response FIFO: registered storage, head driven to zero when empty,
// flush wins over push/pop.
module fp_fma_sched_fifo
    import fp_fma_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush_i,
    input  logic          push_i,
    input  fp_rnd_in_type push_data_i,
    input  logic          pop_i,
    output logic          valid_o,
    output fp_rnd_in_type head_o,
    output logic [AW:0]   occ_o
);

    fp_rnd_in_type r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_occ;

    always_ff @(posedge clock) begin
        if (push_i && !flush_i) begin
            r_mem[r_wr] <= push_data_i;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset || flush_i) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_occ <= '0;
        end else begin
            if (push_i) r_wr <= r_wr + AW'(1);
            if (pop_i)  r_rd <= r_rd + AW'(1);
            case ({push_i, pop_i})
                2'b10:   r_occ <= r_occ + (AW+1)'(1);
                2'b01:   r_occ <= r_occ - (AW+1)'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign valid_o = (r_occ != '0);
    assign head_o  = valid_o ? r_mem[r_rd] : init_fp_rnd_in;
    assign occ_o   = r_occ;

endmodule

// File: rtl/fp_fma_sched.sv
// Shares one non-stallable FMA pipeline between NREQ requesters: credit-gated
// round-robin issue, a tag pipe matching FMA latency, per-requester response FIFOs.
module fp_fma_sched
    import fp_fma_sched_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int LAT   = 4,
    parameter int DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush_i,
    input  logic [NREQ-1:0] req_valid_i,
    output logic [NREQ-1:0] req_ready_o,
    input  fp_fma_in_type   req_data_i [NREQ],
    output fp_fma_in_type   fma_req_o,
    input  fp_fma_out_type  fma_rsp_i,
    output logic [NREQ-1:0] rsp_valid_o,
    input  logic [NREQ-1:0] rsp_ready_i,
    output fp_rnd_in_type   rsp_data_o [NREQ],
    output logic            err_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int QW = $clog2(LAT + 1);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    // Both sides transfer on valid & ready at a rising edge; req_ready_o is a
    // function of req_valid_i, rsp_valid_o never depends on rsp_ready_i.
    logic [CW-1:0]        w_occ [NREQ];
    logic [CW-1:0]        r_inflight [NREQ];
    logic [NREQ-1:0]      w_elig, w_gnt, w_ret, w_push, w_pop, w_rsp_valid;
    logic                 w_any;
    logic [1:0]           w_gnt_id;
    fp_fma_in_type        w_issue;
    fp_fma_sched_tag_type r_tag [LAT+1];
    fp_fma_in_type        r_issue;
    logic [1:0]           r_ptr;
    logic                 r_err;
    logic [QW-1:0]        r_quiet;

    always_comb begin
        w_elig   = '0;
        w_gnt    = '0;
        w_any    = 1'b0;
        w_gnt_id = '0;
        w_issue  = init_fp_fma_in;
        for (int i = 0; i < NREQ; i++) begin
            w_elig[i] = reset & ~flush_i & req_valid_i[i] &
                        (({1'b0, w_occ[i]} + {1'b0, r_inflight[i]}) < DEPTH_C);
        end
        // Two passes give rotating priority: indices at/after the pointer first.
        for (int i = 0; i < NREQ; i++) begin
            if (!w_any && w_elig[i] && (2'(i) >= r_ptr)) begin
                w_any    = 1'b1;
                w_gnt_id = 2'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_any && w_elig[i]) begin
                w_any    = 1'b1;
                w_gnt_id = 2'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            w_gnt[i] = w_any && (w_gnt_id == 2'(i));
            if (w_gnt[i]) w_issue = req_data_i[i];
            w_ret[i]  = r_tag[LAT].valid && (r_tag[LAT].id == 2'(i));
            w_push[i] = w_ret[i] && !r_tag[LAT].drop;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int j = 0; j <= LAT; j++) r_tag[j] <= init_fp_fma_sched_tag;
            for (int i = 0; i < NREQ; i++) r_inflight[i] <= '0;
            r_issue <= init_fp_fma_in;
            r_ptr   <= '0;
            r_err   <= 1'b0;
            r_quiet <= QW'(LAT);
        end else begin
            r_tag[0].valid <= w_any;
            r_tag[0].drop  <= 1'b0;
            r_tag[0].id    <= w_gnt_id;
            for (int j = 1; j <= LAT; j++) begin
                r_tag[j].valid <= r_tag[j-1].valid;
                r_tag[j].id    <= r_tag[j-1].id;
                r_tag[j].drop  <= r_tag[j-1].drop | flush_i;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (w_gnt[i] && !w_ret[i])      r_inflight[i] <= r_inflight[i] + CW'(1);
                else if (!w_gnt[i] && w_ret[i]) r_inflight[i] <= r_inflight[i] - CW'(1);
            end
            r_issue <= w_issue;
            if (w_any) r_ptr <= (w_gnt_id == 2'(NREQ-1)) ? 2'd0 : w_gnt_id + 2'd1;
            // Results issued before reset may still drain out of the FMA for LAT cycles.
            if (r_quiet != '0) r_quiet <= r_quiet - QW'(1);
            else if (fma_rsp_i.ready != r_tag[LAT].valid) r_err <= 1'b1;
        end
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_req
        assign w_pop[i] = w_rsp_valid[i] & rsp_ready_i[i];
        fp_fma_sched_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clock       (clock),
            .reset       (reset),
            .flush_i     (flush_i),
            .push_i      (w_push[i]),
            .push_data_i (fma_rsp_i.fp_rnd),
            .pop_i       (w_pop[i]),
            .valid_o     (w_rsp_valid[i]),
            .head_o      (rsp_data_o[i]),
            .occ_o       (w_occ[i])
        );
    end

    assign req_ready_o = w_gnt;
    assign rsp_valid_o = w_rsp_valid;
    assign fma_req_o   = r_issue;
    assign err_o       = r_err;

endmodule
